// File: rtl/score_pkg.sv
// Shared types and constants for the score table: FSM state encoding and BCD digit width.
package score_pkg;

  localparam int unsigned DigitW = 4;
  localparam int unsigned BlankCharDefault = 36;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StShift,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/bcd_accum.sv
// Saturating multi-digit BCD accumulator; clear has priority over add, invalid digits are ignored.
module bcd_accum
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  localparam int unsigned ScoreW = DIGITS * DigitW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [3:0]        add_val,
  output logic [ScoreW-1:0] score
);

  logic [ScoreW-1:0] score_q, score_d;
  logic [ScoreW-1:0] sum;
  logic [4:0]        dsum;
  logic [3:0]        carry;

  always_comb begin
    sum   = score_q;
    carry = add_val;
    dsum  = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      dsum = {1'b0, score_q[d*DigitW +: DigitW]} + {1'b0, carry};
      if (dsum > 5'd9) begin
        sum[d*DigitW +: DigitW] = 4'(dsum - 5'd10);
        carry = 4'd1;
      end else begin
        sum[d*DigitW +: DigitW] = dsum[3:0];
        carry = 4'd0;
      end
    end
  end

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (add_en && (add_val <= 4'd9)) begin
      // A carry out of the top digit means the true sum exceeds all-9s.
      score_d = (carry != 4'd0) ? {DIGITS{4'h9}} : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/score_table.sv
// Game score accumulator plus a sorted high-score table filled by a scan/shift/write insertion FSM.
module score_table
  import score_pkg::*;
#(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned NAME_LEN   = 5,
  parameter int unsigned CHAR_W     = 6,
  parameter int unsigned BLANK_CHAR = BlankCharDefault,
  localparam int unsigned ScoreW = DIGITS * DigitW,
  localparam int unsigned NameW  = NAME_LEN * CHAR_W,
  localparam int unsigned IdxW   = $clog2(ENTRIES),
  localparam int unsigned RankW  = $clog2(ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_score,
  input  logic              add_en,
  input  logic [3:0]        add_val,
  input  logic              save_req,
  input  logic [NameW-1:0]  name_in,
  input  logic [IdxW-1:0]   rd_idx,
  output logic [ScoreW-1:0] score,
  output logic [ScoreW-1:0] rd_score,
  output logic [NameW-1:0]  rd_name,
  output logic              save_busy,
  output logic              save_done,
  output logic [RankW-1:0]  save_rank
);

  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(ENTRIES - 1);
  localparam logic [NameW-1:0] BlankName = {NAME_LEN{CHAR_W'(BLANK_CHAR)}};

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   rank_q, rank_d;
  logic [ScoreW-1:0] snap_score_q, snap_score_d;
  logic [NameW-1:0]  snap_name_q, snap_name_d;
  logic [RankW-1:0]  save_rank_q, save_rank_d;
  logic [ScoreW-1:0] tbl_score_q [ENTRIES];
  logic [ScoreW-1:0] tbl_score_d [ENTRIES];
  logic [NameW-1:0]  tbl_name_q  [ENTRIES];
  logic [NameW-1:0]  tbl_name_d  [ENTRIES];

  bcd_accum #(
    .DIGITS (DIGITS)
  ) u_bcd_accum (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_score),
    .add_en  (add_en),
    .add_val (add_val),
    .score   (score)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rank_d       = rank_q;
    snap_score_d = snap_score_q;
    snap_name_d  = snap_name_q;
    save_rank_d  = save_rank_q;
    tbl_score_d  = tbl_score_q;
    tbl_name_d   = tbl_name_q;
    unique case (state_q)
      StIdle: begin
        if (save_req) begin
          snap_score_d = score;
          snap_name_d  = name_in;
          idx_d        = '0;
          state_d      = StScan;
        end
      end
      StScan: begin
        // Strictly greater: a tie leaves the existing entry ahead of the new one.
        if (snap_score_q > tbl_score_q[idx_q]) begin
          rank_d = idx_q;
          if (idx_q != LastIdx) begin
            idx_d   = LastIdx;
            state_d = StShift;
          end else begin
            state_d = StWrite;
          end
        end else if (idx_q == LastIdx) begin
          save_rank_d = RankW'(ENTRIES);
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StShift: begin
        tbl_score_d[idx_q] = tbl_score_q[idx_q - 1'b1];
        tbl_name_d[idx_q]  = tbl_name_q[idx_q - 1'b1];
        if (idx_q == rank_q + 1'b1) begin
          state_d = StWrite;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StWrite: begin
        tbl_score_d[rank_q] = snap_score_q;
        tbl_name_d[rank_q]  = snap_name_q;
        save_rank_d         = RankW'(rank_q);
        state_d             = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      rank_q       <= '0;
      snap_score_q <= '0;
      snap_name_q  <= '0;
      save_rank_q  <= RankW'(ENTRIES);
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_score_q[i] <= '0;
        tbl_name_q[i]  <= BlankName;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rank_q       <= rank_d;
      snap_score_q <= snap_score_d;
      snap_name_q  <= snap_name_d;
      save_rank_q  <= save_rank_d;
      tbl_score_q  <= tbl_score_d;
      tbl_name_q   <= tbl_name_d;
    end
  end

  assign rd_score  = tbl_score_q[rd_idx];
  assign rd_name   = tbl_name_q[rd_idx];
  assign save_busy = (state_q != StIdle);
  assign save_done = (state_q == StDone);
  assign save_rank = save_rank_q;

endmodule

// File: tb/tb_score_table.sv
// Directed bench for score_table with default parameters (3 digits, 4 entries, 5x6-bit names).
module tb_score_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_score;
  logic        add_en;
  logic [3:0]  add_val;
  logic        save_req;
  logic [29:0] name_in;
  logic [1:0]  rd_idx;
  logic [11:0] score;
  logic [11:0] rd_score;
  logic [29:0] rd_name;
  logic        save_busy;
  logic        save_done;
  logic [2:0]  save_rank;

  int checks = 0;
  int errors = 0;

  localparam logic [29:0] Blank = {5{6'd36}};

  always #5 clk = ~clk;

  score_table dut (
    .clk         (clk),
    .reset       (reset),
    .clear_score (clear_score),
    .add_en      (add_en),
    .add_val     (add_val),
    .save_req    (save_req),
    .name_in     (name_in),
    .rd_idx      (rd_idx),
    .score       (score),
    .rd_score    (rd_score),
    .rd_name     (rd_name),
    .save_busy   (save_busy),
    .save_done   (save_done),
    .save_rank   (save_rank)
  );

  function automatic logic [29:0] mk_name(input int base);
    logic [29:0] n;
    for (int c = 0; c < 5; c++) n[c*6 +: 6] = 6'(base + c);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] v);
    add_en = 1'b1;
    add_val = v;
    tick();
    add_en = 1'b0;
  endtask

  task automatic set_score(input int n);
    int rem;
    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;
    rem = n;
    while (rem > 0) begin
      add(4'((rem > 9) ? 9 : rem));
      rem -= (rem > 9) ? 9 : rem;
    end
  endtask

  // Returns observed latency (cycles after the accepting cycle) and rank.
  task automatic run_save(input logic [29:0] nm, output int lat, output logic [2:0] rank);
    name_in = nm;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    lat = 1;
    while (!save_done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (!save_done) begin
      errors++;
      $display("FAIL save_timeout: save_done=%0b required 1", save_done);
    end
    rank = save_rank;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (score !== 12'h000) begin
      errors++; $display("FAIL reset_score: got %h required 000", score);
    end
    checks++;
    if (save_rank !== 3'd4 || save_done !== 1'b0 || save_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: rank=%0d done=%0b busy=%0b required 4 0 0",
               save_rank, save_done, save_busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_score !== 12'h000 || rd_name !== Blank) begin
        errors++;
        $display("FAIL reset_entry%0d: got %h/%h required 000/%h", i, rd_score, rd_name, Blank);
      end
    end
  endtask

  task automatic test_bcd();
    set_score(95);
    checks++;
    if (score !== 12'h095) begin
      errors++; $display("FAIL bcd_build: got %h required 095", score);
    end
    add(4'd9);
    checks++;
    if (score !== 12'h104) begin
      errors++; $display("FAIL bcd_carry: got %h required 104", score);
    end
    add(4'd12);
    checks++;
    if (score !== 12'h104) begin
      errors++; $display("FAIL bcd_invalid: got %h required 104", score);
    end
    set_score(99);
    add(4'd1);
    checks++;
    if (score !== 12'h100) begin
      errors++; $display("FAIL bcd_chain: got %h required 100", score);
    end
    set_score(990);
    add(4'd9);
    checks++;
    if (score !== 12'h999) begin
      errors++; $display("FAIL bcd_reach999: got %h required 999", score);
    end
    add(4'd5);
    checks++;
    if (score !== 12'h999) begin
      errors++; $display("FAIL bcd_saturate: got %h required 999", score);
    end
    clear_score = 1'b1;
    add(4'd3);
    clear_score = 1'b0;
    checks++;
    if (score !== 12'h000) begin
      errors++; $display("FAIL clear_priority: got %h required 000", score);
    end
  endtask

  task automatic test_insert();
    logic [11:0] exp_s [4];
    logic [29:0] exp_n [4];
    int lat;
    logic [2:0] rank;
    set_score(50);
    run_save(mk_name(1), lat, rank);
    checks++;
    if (rank !== 3'd0 || lat != 6) begin
      errors++; $display("FAIL insert_050: rank=%0d lat=%0d required 0 6", rank, lat);
    end
    set_score(80);
    run_save(mk_name(7), lat, rank);
    checks++;
    if (rank !== 3'd0 || lat != 6) begin
      errors++; $display("FAIL insert_080: rank=%0d lat=%0d required 0 6", rank, lat);
    end
    set_score(20);
    run_save(mk_name(13), lat, rank);
    checks++;
    if (rank !== 3'd2 || lat != 6) begin
      errors++; $display("FAIL insert_020: rank=%0d lat=%0d required 2 6", rank, lat);
    end
    exp_s = '{12'h080, 12'h050, 12'h020, 12'h000};
    exp_n = '{mk_name(7), mk_name(1), mk_name(13), Blank};
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_score !== exp_s[i] || rd_name !== exp_n[i]) begin
        errors++;
        $display("FAIL insert_entry%0d: got %h/%h required %h/%h",
                 i, rd_score, rd_name, exp_s[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_tie_full();
    logic [11:0] exp_s [4];
    logic [29:0] exp_n [4];
    int lat;
    logic [2:0] rank;
    set_score(10);
    run_save(mk_name(19), lat, rank);
    checks++;
    if (rank !== 3'd3 || lat != 6) begin
      errors++; $display("FAIL fill_010: rank=%0d lat=%0d required 3 6", rank, lat);
    end
    set_score(50);
    run_save(mk_name(25), lat, rank);
    checks++;
    if (rank !== 3'd2 || lat != 6) begin
      errors++; $display("FAIL tie_050: rank=%0d lat=%0d required 2 6", rank, lat);
    end
    set_score(5);
    run_save(mk_name(30), lat, rank);
    checks++;
    if (rank !== 3'd4 || lat != 5) begin
      errors++; $display("FAIL unplaced_005: rank=%0d lat=%0d required 4 5", rank, lat);
    end
    exp_s = '{12'h080, 12'h050, 12'h050, 12'h020};
    exp_n = '{mk_name(7), mk_name(1), mk_name(25), mk_name(13)};
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_score !== exp_s[i] || rd_name !== exp_n[i]) begin
        errors++;
        $display("FAIL tie_entry%0d: got %h/%h required %h/%h",
                 i, rd_score, rd_name, exp_s[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_busy();
    logic [11:0] exp_s [4];
    int lat;
    set_score(90);
    name_in = mk_name(2);
    save_req = 1'b1;
    tick();
    checks++;
    if (save_busy !== 1'b1) begin
      errors++; $display("FAIL busy_scan: busy=%0b required 1", save_busy);
    end
    name_in = mk_name(9);
    add_en = 1'b1;
    add_val = 4'd5;
    tick();
    add_en = 1'b0;
    save_req = 1'b0;
    lat = 2;
    while (!save_done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (save_done !== 1'b1 || save_rank !== 3'd0 || lat != 6) begin
      errors++;
      $display("FAIL busy_save: done=%0b rank=%0d lat=%0d required 1 0 6",
               save_done, save_rank, lat);
    end
    checks++;
    if (score !== 12'h095) begin
      errors++; $display("FAIL busy_add: got %h required 095", score);
    end
    tick();
    tick();
    checks++;
    if (save_busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignored_req: busy=%0b required 0", save_busy);
    end
    exp_s = '{12'h090, 12'h080, 12'h050, 12'h050};
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_score !== exp_s[i]) begin
        errors++; $display("FAIL busy_entry%0d: got %h required %h", i, rd_score, exp_s[i]);
      end
    end
    rd_idx = 2'd0;
    #1;
    checks++;
    if (rd_name !== mk_name(2)) begin
      errors++; $display("FAIL busy_snap_name: got %h required %h", rd_name, mk_name(2));
    end
  endtask

  task automatic test_reset_abort();
    int seen_done = 0;
    set_score(95);
    name_in = mk_name(4);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    if (save_done) seen_done++;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (save_done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL abort_done: saw %0d save_done cycles required 0", seen_done);
    end
    checks++;
    if (save_busy !== 1'b0 || save_rank !== 3'd4 || score !== 12'h000) begin
      errors++;
      $display("FAIL abort_status: busy=%0b rank=%0d score=%h required 0 4 000",
               save_busy, save_rank, score);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_score !== 12'h000 || rd_name !== Blank) begin
        errors++;
        $display("FAIL abort_entry%0d: got %h/%h required 000/%h", i, rd_score, rd_name, Blank);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_score = 1'b0;
    add_en = 1'b0;
    add_val = 4'd0;
    save_req = 1'b0;
    name_in = '0;
    rd_idx = 2'd0;
    test_reset();
    test_bcd();
    test_insert();
    test_tie_full();
    test_busy();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_table.md
SCORE_TABLE -- requirements
Module: score_table

Interface
REQ-001 Parameters SHALL be:
- DIGITS, default 3: BCD digits of score.
- ENTRIES, default 4: high-score table depth, ≥2.
- NAME_LEN, default 5: characters per name.
- CHAR_W, default 6: bits per character.
- BLANK_CHAR, default 36: code for the empty-name character.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_score  in  1  pulse; zero the current score (new game).
- add_en  in  1  pulse; add add_val to the current score.
- add_val  in  4  BCD increment, 0..9.
- save_req  in  1  pulse; offer the current score and name_in to the table.
- name_in  in  NAME_LEN*CHAR_W  name; char 0 in the LSBs.
- rd_idx  in  clog2(ENTRIES)  table read index; 0 is the highest entry.
- score  out  DIGITS*4  current score, BCD; digit 0 in the LSBs.
- rd_score  out  DIGITS*4  score of entry rd_idx (combinational read).
- rd_name  out  NAME_LEN*CHAR_W  name of entry rd_idx (combinational read).
- save_busy  out  1  high while the insertion FSM is not IDLE.
- save_done  out  1  one-cycle pulse when a save completes.
- save_rank  out  clog2(ENTRIES+1)  final rank of the last save; ENTRIES means not placed.

Function
REQ-003 The score SHALL be a DIGITS-digit BCD accumulator; add_en adds add_val with decimal carry in the same cycle.
REQ-004 If add_val>9, add_en SHALL leave the score unchanged.
REQ-005 The score SHALL saturate at all-9s and never wrap.
REQ-006 If clear_score and add_en occur in the same cycle, clear_score SHALL win and the score SHALL be 0.
REQ-007 add_en and clear_score SHALL be honoured regardless of save_busy.
REQ-008 The FSM SHALL have states IDLE, SCAN, SHIFT, WRITE, DONE.
REQ-009 save_req SHALL be accepted only in IDLE; on acceptance, score and name_in are snapshotted the same cycle and the FSM enters SCAN. save_req outside IDLE SHALL be ignored.
REQ-010 SCAN SHALL compare the snapshot against entry i, with i=0 on the first SCAN cycle and one entry per cycle.
REQ-011 The rank SHALL be the first i where snapshot > entry i, strictly greater; on a tie the existing entry keeps its rank.
REQ-012 If no entry qualifies after entry ENTRIES-1, the FSM SHALL go to DONE with rank=ENTRIES and leave the table unchanged.
REQ-013 On finding a rank, the FSM SHALL go to SHIFT when rank<ENTRIES-1, else to WRITE.
REQ-014 SHIFT SHALL copy entry j-1 to entry j, one j per cycle, j from ENTRIES-1 down to rank+1; entry ENTRIES-1 is discarded. Then WRITE.
REQ-015 WRITE SHALL store the snapshot score and name at rank, then go to DONE.
REQ-016 DONE SHALL pulse save_done, update save_rank, and return to IDLE next cycle.
REQ-017 save_busy SHALL be 1 in SCAN, SHIFT, WRITE and DONE.
REQ-018 Total save latency SHALL be (rank+1) SCAN + (ENTRIES-1-rank) SHIFT + 1 WRITE + 1 DONE cycles; an unplaced save takes ENTRIES+1 cycles.
REQ-019 rd_score and rd_name SHALL reflect the table contents as registered at the current cycle; mid-insertion values are visible.

Reset
REQ-020 On reset:
- score = 0, save_rank = ENTRIES, save_done = 0, save_busy = 0, FSM in IDLE.
- Every table score = 0; every name character = BLANK_CHAR.
REQ-021 Reset mid-save SHALL abort the save with no save_done, and reset SHALL take priority over all other inputs.

Structure
REQ-022 Package score_pkg SHALL hold the FSM state enum, the BCD digit width constant (4), and the BLANK_CHAR default.
REQ-023 The BCD add/saturate SHALL be a sub-module bcd_accum, parametrised by DIGITS; the table and FSM stay in score_table.

Verification
REQ-024 Carry and saturation: add 9 to score 095 -> 104; from 999, add 5 -> stays 999; add_val=12 -> no change.
REQ-025 Clear priority: clear_score and add_en(3) in the same cycle -> score 000.
REQ-026 Insertion order: save 050, then 080, then 020 from reset -> entries 080, 050, 020, 000; save_rank values 0, 0, 2.
REQ-027 Tie and full table:
- With table 080/050/020/010, save 050 -> rank 2; table becomes 080/050/050/020.
- With that table, save 005 -> rank 4; table unchanged; save_done 5 cycles after acceptance.
REQ-028 Busy handling: save_req while busy -> ignored; add_en during a save -> score changes, but the stored value is the snapshot.
REQ-029 Reset abort: assert reset during SHIFT -> no save_done; table all 000/BLANK; FSM in IDLE.
